// File: rtl/team_06_audio_pkg.sv
// Shared definitions for the speaker-path playback block.
//   i2s_slots()   : bit-clock slots in one stereo I2S frame for a given sample width
//   level_width() : width of an occupancy counter able to hold 0..depth
//   under_mode_e  : what is sent when the sample FIFO runs dry
package team_06_audio_pkg;

    typedef enum logic {
        UNDER_ZERO   = 1'b0,
        UNDER_REPEAT = 1'b1
    } under_mode_e;

    function automatic int i2s_slots(input int data_w);
        return 2 * data_w;
    endfunction

    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/team_06_sample_fifo.sv
// Sample FIFO between the SPI receiver and the I2S serialiser.
// Up to two entries can be popped in one cycle (stereo frame load).
//   clk, rst      : clock, synchronous active-high reset
//   flush         : empties the FIFO on the next edge, ignores that cycle's push
//   push, wr_data : write strobe and sample
//   pop_req       : number of entries wanted this cycle (0..2)
//   pop_cnt       : number actually granted (limited by occupancy, no bypass)
//   rd_data0/1    : head entry and the one behind it
//   full, empty   : occupancy status
//   level         : exact occupancy, registered
module team_06_sample_fifo
    import team_06_audio_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int LVL_W = level_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [1:0]        pop_req,
    output logic [1:0]        pop_cnt,
    output logic [DATA_W-1:0] rd_data0,
    output logic [DATA_W-1:0] rd_data1,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;

    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);
    assign rd_data0 = mem[rd_ptr];
    assign rd_data1 = mem[rd_ptr + AW'(1)];

    // A push into a full FIFO still succeeds when an entry leaves in the same cycle.
    always_comb begin
        pop_cnt = 2'd0;
        if (pop_req != 2'd0 && !empty) begin
            pop_cnt = (pop_req == 2'd2 && level >= LVL_W'(2)) ? 2'd2 : 2'd1;
        end
        push_ok = push && (!full || pop_cnt != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush && !rst) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr + AW'(pop_cnt);
            level  <= level + LVL_W'(push_ok) - LVL_W'(pop_cnt);
        end
    end

endmodule

// File: rtl/team_06_i2s_playback_engine.sv
// Speaker-path playback: FIFO-buffered samples, mute/attenuation, I2S serialiser
// driven from an internally divided bit clock.
//   clk, rst                 : clock, synchronous active-high reset
//   en                       : playback enable (low = standby, FIFO flushed)
//   sample_in, sample_valid  : samples from the SPI receiver
//   atten, mute              : arithmetic right-shift amount, force silence
//   i2sclk, word_select,
//   serial_out               : I2S bus to the DAC (data changes on i2sclk fall)
//   level                    : FIFO occupancy
//   overflow, underflow      : sticky error flags, cleared by clr_flags
module team_06_i2s_playback_engine
    import team_06_audio_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 16,
    parameter int CLK_DIV    = 7,
    parameter int STEREO     = 0,
    parameter int UNDER_HOLD = 1,
    localparam int LVL_W     = level_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic [3:0]        atten,
    input  logic              mute,
    output logic              i2sclk,
    output logic              word_select,
    output logic              serial_out,
    output logic [LVL_W-1:0]  level,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_flags
);
    localparam int SLOTS = i2s_slots(DATA_W);
    localparam int KW    = $clog2(SLOTS);
    localparam int DW    = $clog2(CLK_DIV);
    localparam under_mode_e UNDER_MODE = (UNDER_HOLD != 0) ? UNDER_REPEAT : UNDER_ZERO;

    logic [DW-1:0]     div_cnt;
    logic [KW-1:0]     slot;
    logic [SLOTS-1:0]  shreg;
    logic [DATA_W-1:0] last_sample;
    logic [DATA_W-1:0] d0, d1, hold_val, l_raw, r_raw;
    logic [1:0]        pop_req, pop_cnt;
    logic              half_done, fall, load, push, full, empty;
    logic              ovf_evt, udf_evt;

    function automatic logic [DATA_W-1:0] scale(input logic [DATA_W-1:0] s,
                                                input logic [3:0] sh, input logic m);
        if (m || int'(sh) >= DATA_W) return '0;
        return $signed(s) >>> sh;
    endfunction

    assign half_done = (div_cnt == DW'(CLK_DIV - 1));
    assign fall      = en && half_done && i2sclk;
    assign load      = fall && (slot == '0);
    assign pop_req   = !load ? 2'd0 : (STEREO != 0) ? 2'd2 : 2'd1;
    assign push      = en && sample_valid;

    team_06_sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (!en),
        .push     (push),
        .wr_data  (sample_in),
        .pop_req  (pop_req),
        .pop_cnt  (pop_cnt),
        .rd_data0 (d0),
        .rd_data1 (d1),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

    // Raw (unscaled) samples for the frame; the held sample is stored raw so a
    // repeat is attenuated once, with the current setting.
    always_comb begin
        hold_val = (UNDER_MODE == UNDER_REPEAT) ? last_sample : '0;
        l_raw    = (pop_cnt != 2'd0) ? d0 : hold_val;
        r_raw    = l_raw;
        if (STEREO != 0) begin
            if (pop_cnt == 2'd2)      r_raw = d1;
            else if (pop_cnt == 2'd1) r_raw = (UNDER_MODE == UNDER_REPEAT) ? d0 : '0;
            else                      r_raw = hold_val;
        end
    end

    assign ovf_evt = push && full && (pop_cnt == 2'd0);
    assign udf_evt = load && (empty || (STEREO != 0 && pop_cnt != 2'd2));

    // Each falling edge emits the shifter MSB and starts a slot. At slot 0 the
    // MSB is still the previous right LSB, so the new frame is loaded behind it
    // and its left MSB lands in slot 1, one slot after WS drops. WS is driven a
    // slot ahead of the data word it names.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div_cnt     <= '0;
            i2sclk      <= 1'b0;
            word_select <= 1'b0;
            serial_out  <= 1'b0;
            slot        <= '0;
            shreg       <= '0;
        end else begin
            if (half_done) begin
                div_cnt <= '0;
                i2sclk  <= ~i2sclk;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
            if (fall) begin
                slot        <= (slot == KW'(SLOTS - 1)) ? '0 : slot + KW'(1);
                word_select <= (slot >= KW'(DATA_W));
                serial_out  <= shreg[SLOTS-1];
                shreg       <= load ? {scale(l_raw, atten, mute), scale(r_raw, atten, mute)}
                                    : {shreg[SLOTS-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_sample <= '0;
        end else if (load) begin
            last_sample <= r_raw;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_flags) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_evt) overflow  <= 1'b1;
            if (udf_evt) underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_team_06_i2s_playback_engine.sv
// Directed bench: a mono/hold instance (defaults) and a stereo/zero-fill instance.
// Per-slot I2S bits are recorded on every i2sclk fall; frames are compared as
// 16 slots {prev R LSB, L[7:0], R[7:1]}.
module tb_team_06_i2s_playback_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // instance A: mono, hold-on-underflow
    logic       a_en = 1'b0, a_val = 1'b0, a_mute = 1'b0, a_clr = 1'b0;
    logic [7:0] a_in = '0;
    logic [3:0] a_atten = '0;
    logic       a_i2sclk, a_ws, a_so, a_ovf, a_udf;
    logic [4:0] a_level;

    // instance B: stereo, zero-on-underflow, DEPTH 4, CLK_DIV 3
    logic       b_en = 1'b0, b_val = 1'b0, b_clr = 1'b0;
    logic [7:0] b_in = '0;
    logic       b_i2sclk, b_ws, b_so, b_ovf, b_udf;
    logic [2:0] b_level;

    team_06_i2s_playback_engine #(
        .DATA_W(8), .DEPTH(16), .CLK_DIV(7), .STEREO(0), .UNDER_HOLD(1)
    ) u_dut_a (
        .clk(clk), .rst(rst), .en(a_en), .sample_in(a_in), .sample_valid(a_val),
        .atten(a_atten), .mute(a_mute), .i2sclk(a_i2sclk), .word_select(a_ws),
        .serial_out(a_so), .level(a_level), .overflow(a_ovf), .underflow(a_udf),
        .clr_flags(a_clr)
    );

    team_06_i2s_playback_engine #(
        .DATA_W(8), .DEPTH(4), .CLK_DIV(3), .STEREO(1), .UNDER_HOLD(0)
    ) u_dut_b (
        .clk(clk), .rst(rst), .en(b_en), .sample_in(b_in), .sample_valid(b_val),
        .atten(4'd0), .mute(1'b0), .i2sclk(b_i2sclk), .word_select(b_ws),
        .serial_out(b_so), .level(b_level), .overflow(b_ovf), .underflow(b_udf),
        .clr_flags(b_clr)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // slot recorders: {word_select, serial_out} captured just after each i2sclk fall
    logic [1:0] qa[$];
    logic [1:0] qb[$];
    logic pa = 1'b0, pb = 1'b0;
    always @(posedge clk) begin
        #1;
        if (pa === 1'b1 && a_i2sclk === 1'b0) qa.push_back({a_ws, a_so});
        if (pb === 1'b1 && b_i2sclk === 1'b0) qb.push_back({b_ws, b_so});
        pa = a_i2sclk;
        pb = b_i2sclk;
    end

    function automatic logic [15:0] ef(input logic p, input logic [7:0] l, input logic [7:0] r);
        return {p, l, r[7:1]};
    endfunction

    task automatic wait_slots(input bit sel, input int n);
        int c;
        c = 0;
        while (((sel ? qb.size() : qa.size()) < n) && c < 3000) begin
            @(posedge clk); #2;
            c++;
        end
        if (c >= 3000) chk("slot_wait", 32'(sel ? qb.size() : qa.size()), 32'(n));
    endtask

    task automatic get_frame(input bit sel, output logic [15:0] so, output logic [15:0] ws);
        logic [1:0] e;
        so = '0;
        ws = '0;
        wait_slots(sel, 16);
        if ((sel ? qb.size() : qa.size()) >= 16) begin
            for (int j = 0; j < 16; j++) begin
                e = sel ? qb.pop_front() : qa.pop_front();
                so[15-j] = e[0];
                ws[15-j] = e[1];
            end
        end
    endtask

    task automatic push_a(input logic [7:0] v);
        @(negedge clk); a_in = v; a_val = 1'b1;
        @(posedge clk); #2 a_val = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] v);
        @(negedge clk); b_in = v; b_val = 1'b1;
        @(posedge clk); #2 b_val = 1'b0;
    endtask

    task automatic clr_a();
        @(negedge clk); a_clr = 1'b1;
        @(posedge clk); #2 a_clr = 1'b0;
    endtask

    task automatic clr_b();
        @(negedge clk); b_clr = 1'b1;
        @(posedge clk); #2 b_clr = 1'b0;
    endtask

    initial begin
        logic [15:0] so, ws;
        logic [7:0]  v;
        logic        prev;
        logic        pk;
        int          t0, t1;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_i2sclk", 32'(a_i2sclk), 32'd0);
        chk("rst_ws", 32'(a_ws), 32'd0);
        chk("rst_so", 32'(a_so), 32'd0);
        chk("rst_level", 32'(a_level), 32'd0);
        chk("rst_flags", 32'({a_ovf, a_udf}), 32'd0);
        @(negedge clk) rst = 1'b0;

        // basic mono playback, MSB first after WS edge
        @(negedge clk) a_en = 1'b1;
        qa.delete();
        push_a(8'h5A);
        push_a(8'hC3);
        chk("t1_level2", 32'(a_level), 32'd2);
        get_frame(0, so, ws);
        chk("t1_f1", 32'(so), 32'(ef(1'b0, 8'h5A, 8'h5A)));
        chk("t1_ws", 32'(ws), 32'h00FF);
        chk("t1_level1", 32'(a_level), 32'd1);
        get_frame(0, so, ws);
        chk("t1_f2", 32'(so), 32'(ef(1'b0, 8'hC3, 8'hC3)));
        chk("t1_udf0", 32'(a_udf), 32'd0);
        get_frame(0, so, ws);
        chk("t4_hold", 32'(so), 32'(ef(1'b1, 8'hC3, 8'hC3)));
        chk("t4_udf1", 32'(a_udf), 32'd1);
        clr_a();
        chk("clr_udf", 32'(a_udf), 32'd0);

        // attenuation and mute
        a_atten = 4'd2;
        push_a(8'h80);
        get_frame(0, so, ws);
        chk("t2_att2", 32'(so), 32'(ef(1'b1, 8'hE0, 8'hE0)));
        a_atten = 4'd9;
        push_a(8'h80);
        get_frame(0, so, ws);
        chk("t2_att9", 32'(so), 32'(ef(1'b0, 8'h00, 8'h00)));
        a_atten = 4'd0;
        a_mute  = 1'b1;
        push_a(8'h7F);
        get_frame(0, so, ws);
        chk("t2_mute", 32'(so), 32'(ef(1'b0, 8'h00, 8'h00)));
        a_mute = 1'b0;
        push_a(8'h3C);
        get_frame(0, so, ws);
        chk("t2_3c", 32'(so), 32'(ef(1'b0, 8'h3C, 8'h3C)));
        chk("t2_udf0", 32'(a_udf), 32'd0);
        get_frame(0, so, ws);
        chk("t4_hold3c", 32'(so), 32'(ef(1'b0, 8'h3C, 8'h3C)));
        chk("t4_udf", 32'(a_udf), 32'd1);

        // drop en mid-frame
        wait_slots(0, 5);
        push_a(8'h55);
        chk("t6_level1", 32'(a_level), 32'd1);
        @(negedge clk) a_en = 1'b0;
        @(posedge clk); #2;
        chk("t6_en_out", 32'({a_i2sclk, a_ws, a_so}), 32'd0);
        chk("t6_en_level", 32'(a_level), 32'd0);
        repeat (3) push_a(8'h77);
        chk("t6_en_push", 32'(a_level), 32'd0);
        chk("t6_flags_kept", 32'({a_ovf, a_udf}), 32'b01);
        chk("t6_idle_out", 32'({a_i2sclk, a_ws, a_so}), 32'd0);

        // rst mid-frame
        @(negedge clk) a_en = 1'b1;
        qa.delete();
        wait_slots(0, 3);
        push_a(8'h66);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #2;
        chk("t6_rst_out", 32'({a_i2sclk, a_ws, a_so}), 32'd0);
        chk("t6_rst_level", 32'(a_level), 32'd0);
        chk("t6_rst_flags", 32'({a_ovf, a_udf}), 32'd0);
        @(negedge clk) rst = 1'b0;
        qa.delete();

        // overflow: 17 pushes into a 16-deep FIFO after the first (empty) load
        wait_slots(0, 1);
        for (int i = 0; i < 17; i++) push_a(8'h10 + 8'(i));
        chk("t3_level16", 32'(a_level), 32'd16);
        chk("t3_ovf", 32'(a_ovf), 32'd1);
        get_frame(0, so, ws);
        chk("t3_f_empty", 32'(so), 32'(ef(1'b0, 8'h00, 8'h00)));
        prev = 1'b0;
        for (int i = 0; i < 16; i++) begin
            v = 8'h10 + 8'(i);
            get_frame(0, so, ws);
            chk($sformatf("t3_drain%0d", i), 32'(so), 32'(ef(prev, v, v)));
            prev = v[0];
        end
        get_frame(0, so, ws);
        chk("t3_no17th", 32'(so), 32'(ef(1'b1, 8'h1F, 8'h1F)));
        chk("t3_level0", 32'(a_level), 32'd0);
        @(negedge clk) a_en = 1'b0;

        // stereo, zero fill
        @(negedge clk) b_en = 1'b1;
        qb.delete();
        push_b(8'h11);
        push_b(8'h23);
        chk("t5_level2", 32'(b_level), 32'd2);
        get_frame(1, so, ws);
        chk("t5_lr", 32'(so), 32'(ef(1'b0, 8'h11, 8'h23)));
        chk("t5_ws", 32'(ws), 32'h00FF);
        get_frame(1, so, ws);
        chk("t5_zero", 32'(so), 32'(ef(1'b1, 8'h00, 8'h00)));
        chk("t5_udf", 32'(b_udf), 32'd1);
        clr_b();
        push_b(8'h44);
        get_frame(1, so, ws);
        chk("t5_half", 32'(so), 32'(ef(1'b0, 8'h44, 8'h00)));
        chk("t5_udf_r", 32'(b_udf), 32'd1);
        wait_slots(1, 2);
        for (int i = 0; i < 5; i++) push_b(8'hA0 + 8'(i));
        chk("t5_level4", 32'(b_level), 32'd4);
        chk("t5_ovf", 32'(b_ovf), 32'd1);

        // bit clock period in clk cycles
        pk = b_i2sclk;
        t0 = -1;
        t1 = -1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #2;
            if (!pk && b_i2sclk) begin
                if (t0 < 0) t0 = i;
                else begin
                    t1 = i;
                    break;
                end
            end
            pk = b_i2sclk;
        end
        chk("t5_period", 32'(t1 - t0), 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
